// File: rtl/rst_lane_sched_4bit.sv
// rst_lane_sched_4bit: staggered reset release and round-robin soft-reset arbiter for a 4-lane datapath
module rst_lane_sched_4bit #(
  parameter int unsigned STAGGER = 4,
  parameter int unsigned HOLD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] soft_req,
  input  logic       a,
  input  logic [3:0] b,
  output logic [3:0] lane_rst,
  output logic [3:0] lane_en,
  output logic [3:0] soft_ack,
  output logic       busy,
  output logic       q,
  output logic [3:0] out
);
  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_REL  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_SOFT = 3'd4;
  localparam logic [7:0] STG = 8'(STAGGER - 1);
  localparam logic [7:0] HLD = 8'(HOLD - 1);
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] li_q, li_d, g_q, g_d, rr_q, rr_d, sync_q, off, gnt;
  logic [3:0] lane_rst_d, lane_en_d, soft_ack_d, rot;
  logic       busy_d;
  // rotate requests so bit 0 is the lane at rr_q, then pick the lowest set bit
  assign rot = 4'({soft_req, soft_req} >> rr_q);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign gnt = rr_q + off;
  assign lane_en_d = ~lane_rst & ~lane_rst_d;
  assign out = b & lane_en;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    li_d = li_q;
    g_d = g_q;
    rr_d = rr_q;
    lane_rst_d = lane_rst;
    soft_ack_d = '0;
    busy_d = busy;
    case (state_q)
      S_RST: state_d = S_SYNC;
      S_SYNC: if (sync_q[1]) begin
        state_d = S_REL;
        lane_rst_d[0] = 1'b0;
        li_d = 2'd1;
        cnt_d = '0;
      end
      S_REL: if (cnt_q == STG) begin
        lane_rst_d[li_q] = 1'b0;
        li_d = li_q + 2'd1;
        cnt_d = '0;
        if (li_q == 2'd3) begin
          state_d = S_RUN;
          busy_d = 1'b0;
        end
      end else cnt_d = cnt_q + 8'd1;
      S_RUN: if (|soft_req) begin
        state_d = S_SOFT;
        lane_rst_d[gnt] = 1'b1;
        g_d = gnt;
        busy_d = 1'b1;
        cnt_d = '0;
      end
      S_SOFT: if (cnt_q == HLD) begin
        state_d = S_RUN;
        lane_rst_d[g_q] = 1'b0;
        soft_ack_d[g_q] = 1'b1;
        rr_d = g_q + 2'd1;
        busy_d = 1'b0;
        cnt_d = '0;
      end else cnt_d = cnt_q + 8'd1;
      default: state_d = S_RST;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      sync_q <= '0;
      cnt_q <= '0;
      li_q <= '0;
      g_q <= '0;
      rr_q <= '0;
      lane_rst <= 4'b1111;
      lane_en <= '0;
      soft_ack <= '0;
      busy <= 1'b1;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], 1'b1};
      cnt_q <= cnt_d;
      li_q <= li_d;
      g_q <= g_d;
      rr_q <= rr_d;
      lane_rst <= lane_rst_d;
      lane_en <= lane_en_d;
      soft_ack <= soft_ack_d;
      busy <= busy_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else if (lane_rst[0]) q <= 1'b0;
    else if (lane_en[0]) q <= a;
  end
endmodule

// File: tb/tb_rst_lane_sched_4bit.sv
// tb_rst_lane_sched_4bit: directed and random stimulus checked against an edge-timestamp reference model
module tb_rst_lane_sched_4bit;
  localparam int S = 4;
  localparam int H = 3;
  localparam int R = 3 + 3 * S;
  logic clk = 1'b0, rst = 1'b0, a = 1'b0;
  logic [3:0] soft_req = '0, b = '0;
  logic [3:0] lane_rst, lane_en, soft_ack, out_w;
  logic busy, q;
  int checks = 0, errors = 0;
  int e, g, gs, rr;
  logic [3:0] x_rst, x_en, x_ack, p_rst, p_en;
  logic x_busy, xq;

  rst_lane_sched_4bit #(.STAGGER(S), .HOLD(H)) dut (
    .clk(clk), .rst(rst), .soft_req(soft_req), .a(a), .b(b),
    .lane_rst(lane_rst), .lane_en(lane_en), .soft_ack(soft_ack),
    .busy(busy), .q(q), .out(out_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h at edge %0d", tag, obs, exp, e);
    end
  endtask

  task automatic check_all();
    chk("lane_rst", lane_rst, x_rst);
    chk("lane_en", lane_en, x_en);
    chk("soft_ack", soft_ack, x_ack);
    chk("busy", {3'b0, busy}, {3'b0, x_busy});
    chk("q", {3'b0, q}, {3'b0, xq});
    chk("out", out_w, b & x_en);
  endtask

  task automatic model_reset();
    e = 0; g = -1; gs = 0; rr = 0;
    x_rst = 4'b1111; x_en = '0; x_ack = '0; x_busy = 1'b1; xq = 1'b0;
  endtask

  // one rising edge: releases are timestamped from rst falling, a soft reset spans H edges from its grant
  task automatic model_step();
    int ng;
    e++;
    p_rst = x_rst;
    p_en = x_en;
    x_ack = '0;
    if (g >= 0) begin
      if (e == gs + H) begin
        x_ack[g] = 1'b1;
        rr = (g + 1) % 4;
        g = -1;
      end
    end else if (e > R && soft_req != 0) begin
      ng = -1;
      for (int k = 3; k >= 0; k--) if (soft_req[(rr + k) % 4]) ng = (rr + k) % 4;
      g = ng;
      gs = e;
    end
    x_rst = '0;
    for (int i = 0; i < 4; i++) if (e < 3 + i * S) x_rst[i] = 1'b1;
    if (g >= 0) x_rst[g] = 1'b1;
    x_en = ~p_rst & ~x_rst;
    if (p_rst[0]) xq = 1'b0;
    else if (p_en[0]) xq = a;
    x_busy = (e < R) || (g >= 0);
  endtask

  task automatic tick(input logic [3:0] r, input logic ai, input logic [3:0] bi);
    @(negedge clk);
    soft_req = r;
    a = ai;
    b = bi;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  // sub-cycle rst pulse placed between edges
  task automatic do_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    bit found;
    do_rst();
    for (int i = 1; i <= 20; i++) tick(i < 14 ? 4'b1111 : 4'b0000, 1'b0, 4'b1111);
    tick(4'b0100, 1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) tick(4'b0000, 1'(i), 4'b1111);
    for (int i = 0; i < 24; i++) tick(4'b1011, 1'(i), 4'b1111);
    for (int i = 0; i < 3; i++) tick(4'b0000, 1'b1, 4'b1111);
    tick(4'b0001, 1'b0, 4'b1111);
    for (int i = 0; i < 10; i++) tick(4'b0000, 1'(i), 4'b1111);
    do_rst();
    for (int i = 0; i < 18; i++) tick(4'b0000, 1'(i), 4'b1111);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(4'b0010, 1'(i), 4'b1111);
      found = (g == 1) && (e == gs + 1);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL reach_lane1_hold observed %0d expected %0d", found, 1);
    end
    do_rst();
    for (int i = 0; i < 20; i++) tick(4'b0010, 1'(i), 4'b1111);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 120) == 0) do_rst();
      tick(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, 1'($urandom), 4'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
